// File: rtl/noc_flit_packetizer_pkg.sv
// Shared NoC definitions: flit-type codes, header field positions and packetizer state encoding.
// The router uses the same flit-type codes and header field positions.
package noc_flit_packetizer_pkg;

    localparam int unsigned FLIT_TYPE_WIDTH = 2;
    localparam int unsigned PKT_COUNT_WIDTH = 16;
    localparam int unsigned HDR_LEN_LSB     = 20;

    typedef enum logic [FLIT_TYPE_WIDTH-1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_HEAD     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } pkt_state_e;

    // A flit that closes a packet.
    function automatic logic is_last_flit(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/noc_flit_packetizer.sv
// Turns a stream of FIFO words (header + len payload words) into typed NoC flits
// through a single output register stage with ready/valid back-pressure.
module noc_flit_packetizer
    import noc_flit_packetizer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]              fifo_rd_data,
    input  logic                               fifo_rd_empty,
    output logic                               flit_valid,
    output logic [DATA_WIDTH+FLIT_TYPE_WIDTH-1:0] flit_data,
    input  logic                               flit_ready,
    output logic                               busy,
    output logic [PKT_COUNT_WIDTH-1:0]         pkt_count
);

    localparam int unsigned FLIT_WIDTH = DATA_WIDTH + FLIT_TYPE_WIDTH;

    pkt_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [LEN_WIDTH-1:0]  hdr_len;
    flit_type_e            ftype_d;
    flit_type_e            out_type;
    logic                  load_c;
    logic                  deliver_c;
    logic                  flit_valid_d;
    logic [FLIT_WIDTH-1:0] flit_data_d;

    assign hdr_len  = fifo_rd_data[HDR_LEN_LSB +: LEN_WIDTH];
    assign out_type = flit_type_e'(flit_data[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH]);

    // Next-state, pop strobe and next flit register contents.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        ftype_d      = FLIT_BODY;
        flit_valid_d = flit_valid;
        flit_data_d  = flit_data;
        load_c       = !flit_valid || flit_ready;
        fifo_rd_en   = load_c && !fifo_rd_empty && !reset;
        deliver_c    = flit_valid && flit_ready && is_last_flit(out_type);

        if (fifo_rd_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (hdr_len == '0) begin
                        ftype_d = FLIT_HEADTAIL;
                    end else begin
                        ftype_d = FLIT_HEAD;
                        rem_d   = hdr_len;
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        ftype_d = FLIT_TAIL;
                        state_d = ST_IDLE;
                    end else begin
                        ftype_d = FLIT_BODY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            flit_valid_d = 1'b1;
            flit_data_d  = {ftype_d, fifo_rd_data};
        end else if (flit_ready) begin
            flit_valid_d = 1'b0;
        end
    end

    // State, output register stage and delivered-packet counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            flit_valid <= 1'b0;
            flit_data  <= '0;
            busy       <= 1'b0;
            pkt_count  <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            flit_valid <= flit_valid_d;
            flit_data  <= flit_data_d;
            busy       <= (state_d == ST_BODY) || flit_valid_d;
            if (deliver_c) begin
                pkt_count <= pkt_count + PKT_COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Scoreboard bench for noc_flit_packetizer: directed packets through a FIFO model,
// expected flits queued at stimulus time and checked by an independent monitor.
module tb_noc_flit_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_empty;
    logic        flit_valid;
    logic [33:0] flit_data;
    logic        flit_ready;
    logic        busy;
    logic [15:0] pkt_count;

    logic [31:0] mem [256];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr = '0;

    logic [33:0] exp_q [$];
    int          hs_q  [$];
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;

    noc_flit_packetizer #(.DATA_WIDTH(32), .LEN_WIDTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .flit_valid    (flit_valid),
        .flit_data     (flit_data),
        .flit_ready    (flit_ready),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model
    assign fifo_rd_empty = (wr_ptr == rd_ptr);
    assign fifo_rd_data  = mem[rd_ptr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
    end

    // Monitor: every accepted flit is compared against the scoreboard head
    always @(negedge clk) begin
        if (flit_valid && flit_ready) begin
            n_vec++;
            hs_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL flit_unexpected: got %h, expected none", flit_data);
            end else begin
                if (flit_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL flit_data: got %h, expected %h", flit_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic [33:0] e);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 8'd1;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wr_ptr     = '0;
        reset      = 1'b1;
        flit_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset values and pop suppression with a non-empty FIFO
        push_word(32'h1200_0000, 34'h3_1200_0000);
        #1;
        check("rst_rd_en",      64'(fifo_rd_en), 64'd0);
        check("rst_flit_valid", 64'(flit_valid), 64'd0);
        check("rst_flit_data",  64'(flit_data),  64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_pkt_count",  64'(pkt_count),  64'd0);

        // len=0 header -> HEADTAIL one cycle after the pop
        reset = 1'b0;
        #1;
        check("t1_rd_en",       64'(fifo_rd_en), 64'd1);
        check("t1_pre_valid",   64'(flit_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_valid",       64'(flit_valid), 64'd1);
        check("t1_data",        64'(flit_data),  64'h3_1200_0000);
        drain("t1_drain");
        check("t1_pkt_count",   64'(pkt_count),  64'd1);

        // len=3 packet at full rate
        hs_q.delete();
        push_word(32'h2330_0000, 34'h1_2330_0000);
        push_word(32'h0000_000A, 34'h0_0000_000A);
        push_word(32'h0000_000B, 34'h0_0000_000B);
        push_word(32'h0000_000C, 34'h2_0000_000C);
        drain("t2_drain");
        check("t2_flits",       64'(hs_q.size()), 64'd4);
        if (hs_q.size() == 4) check("t2_back_to_back", 64'(hs_q[3] - hs_q[0]), 64'd3);
        check("t2_busy_after",  64'(busy),       64'd0);
        check("t2_pkt_count",   64'(pkt_count),  64'd2);

        // Same packet, router stalls the second flit for 3 cycles
        push_word(32'h2330_0000, 34'h1_2330_0000);
        push_word(32'h0000_000A, 34'h0_0000_000A);
        push_word(32'h0000_000B, 34'h0_0000_000B);
        push_word(32'h0000_000C, 34'h2_0000_000C);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flit_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_data",  64'(flit_data),  64'h0_0000_000A);
            check("t3_hold_rd_en", 64'(fifo_rd_en), 64'd0);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        flit_ready = 1'b1;
        drain("t3_drain");
        check("t3_pkt_count",   64'(pkt_count),  64'd3);

        // len=2 packet with FIFO empty for 5 cycles after the header
        push_word(32'h5520_0000, 34'h1_5520_0000);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_gap_valid", 64'(flit_valid), 64'd0);
            check("t4_gap_busy",  64'(busy),       64'd1);
        end
        push_word(32'h0000_0011, 34'h0_0000_0011);
        push_word(32'h0000_0022, 34'h2_0000_0022);
        drain("t4_drain");
        check("t4_pkt_count",   64'(pkt_count),  64'd4);

        // Reset after HEAD of a len=3 packet discards the rest
        push_word(32'h6630_0000, 34'h1_6630_0000);
        @(posedge clk);
        @(posedge clk); #1;
        check("t5_busy_mid",    64'(busy),       64'd1);
        reset = 1'b1;
        push_word(32'h4000_0000, 34'h3_4000_0000);
        #1;
        check("t5_rst_rd_en",   64'(fifo_rd_en), 64'd0);
        @(posedge clk); #1;
        check("t5_rst_valid",   64'(flit_valid), 64'd0);
        check("t5_rst_data",    64'(flit_data),  64'd0);
        check("t5_rst_busy",    64'(busy),       64'd0);
        check("t5_rst_count",   64'(pkt_count),  64'd0);
        reset = 1'b0;
        drain("t5_drain");
        check("t5_pkt_count",   64'(pkt_count),  64'd1);

        // Fill pkt_count to 65535 with len=0 packets, then wrap
        begin
            int sent = 0;
            while (sent < 65534) begin
                if (8'(wr_ptr - rd_ptr) < 8'd200) begin
                    push_word(32'h0000_0000, 34'h3_0000_0000);
                    sent++;
                end
                @(posedge clk); #1;
            end
        end
        drain("t6_drain_fill");
        check("t6_count_max",   64'(pkt_count),  64'd65535);
        push_word(32'h0000_0000, 34'h3_0000_0000);
        drain("t6_drain_wrap");
        check("t6_count_wrap",  64'(pkt_count),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc_flit_packetizer.md
NOC_FLIT_PACKETIZER -- requirements
Module: noc_flit_packetizer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of a FIFO word and of the flit payload.
REQ-002 Parameter LEN_WIDTH, default 4: width of the header payload-length field, giving 0..15 payload words per packet.
REQ-003 Port clk  input  1  single network-domain clock, rising-edge active.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port fifo_rd_en  output  1  pop strobe to the upstream CDC FIFO read port.
REQ-006 Port fifo_rd_data  input  DATA_WIDTH  show-ahead FIFO head word, valid whenever fifo_rd_empty=0.
REQ-007 Port fifo_rd_empty  input  1  FIFO empty flag.
REQ-008 Port flit_valid  output  1  flit offered to the router.
REQ-009 Port flit_data  output  DATA_WIDTH+2  {flit_type[1:0], payload[DATA_WIDTH-1:0]}.
REQ-010 Port flit_ready  input  1  router accepts the flit this cycle.
REQ-011 Port busy  output  1  high while a packet is in progress or a flit is pending.
REQ-012 Port pkt_count  output  16  count of packets fully delivered.

Function
REQ-013 The first FIFO word of a packet SHALL be its header: dest_x=[31:28], dest_y=[27:24], len=[23:20]; the remaining bits are forwarded unchanged.
REQ-014 Flit types SHALL be 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEADTAIL.
REQ-015 The output SHALL be a single register stage; load = !flit_valid || flit_ready.
REQ-016 fifo_rd_en SHALL equal load && !fifo_rd_empty, combinationally.
REQ-017 On fifo_rd_en, the flit register SHALL capture {type, fifo_rd_data} and set flit_valid=1 on the next edge.
REQ-018 If flit_ready=1 and fifo_rd_en=0, flit_valid SHALL clear on the next edge.
REQ-019 While flit_valid=1 and flit_ready=0, flit_data SHALL be held stable and no pop SHALL occur.
REQ-020 Latency SHALL be one cycle from a pop to flit_valid; sustained throughput SHALL be one flit per cycle.
REQ-021 The FSM SHALL have two states, IDLE (next word is a header) and BODY (rem payload words remain).
REQ-022 IDLE pop with len=0 SHALL emit HEADTAIL and stay in IDLE.
REQ-023 IDLE pop with len>0 SHALL emit HEAD, load rem=len, and move to BODY.
REQ-024 Each BODY pop SHALL decrement rem, emitting BODY if rem>1 beforehand.
REQ-025 A BODY pop with rem=1 beforehand SHALL emit TAIL and return to IDLE.
REQ-026 pkt_count SHALL increment by 1 on each flit_valid && flit_ready cycle where the type is TAIL or HEADTAIL, wrapping from 65535 to 0.
REQ-027 busy SHALL equal (state==BODY) || flit_valid.
REQ-028 FIFO running empty mid-packet SHALL stall emission without a state change; no timeout applies.

Reset
REQ-029 While reset=1 at a rising edge, state SHALL become IDLE, with rem=0, flit_valid=0, flit_data=0, and pkt_count=0.
REQ-030 fifo_rd_en SHALL be 0 during reset regardless of fifo_rd_empty.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet; the next popped word after reset is treated as a header.

Structure
REQ-032 Flit-type codes and header field bit positions SHALL reside in the shared NoC definitions include, also used by the router.
REQ-033 The block SHALL be a single module with no sub-modules; the CDC FIFO is instantiated by the parent.

Verification
REQ-034 Header 0x1200_0000 (len=0), flit_ready=1 -> one flit 0x3_1200_0000 one cycle after the pop; pkt_count becomes 1.
REQ-035 Header 0x2330_0000 plus payloads 0xA, 0xB, 0xC, flit_ready=1 -> types HEAD, BODY, BODY, TAIL on 4 consecutive cycles; busy drops after TAIL.
REQ-036 Same packet with flit_ready low for 3 cycles on the second flit -> flit_data held at 0x0_0000_000A with fifo_rd_en=0 during the stall; order preserved.
REQ-037 len=2 packet with the FIFO empty after the header for 5 cycles -> flit_valid=0 and state BODY during the gap; BODY then TAIL after data arrives.
REQ-038 Reset pulse after HEAD of a len=3 packet -> outputs zeroed; the next word 0x4000_0000 is emitted as HEADTAIL.
REQ-039 Preload pkt_count 65535 via 65535 len=0 packets, then one more -> pkt_count wraps to 0.
